// File: rtl/multi_downloader.sv
// multi_downloader: routes data_io ROM/PRG downloads onto a memory bus
// and patches the BASIC end-of-program pointers after a PRG load.
module multi_downloader #(
   parameter int          AW          = 25,
   parameter logic [AW-1:0] ROM_START = 25'h0,
   parameter logic [AW-1:0] ROM_SIZE  = 25'h4000,
   parameter logic [AW-1:0] PRG_START = 25'h8241,
   parameter logic [AW-1:0] PTR_BASE  = 25'h81BB,
   parameter int          NUM_PTRS    = 1,
   parameter int          PTR_BYTES   = 2,
   parameter logic [7:0]  ROM_INDEX   = 8'h00,
   parameter logic [7:0]  PRG_INDEX_A = 8'h01,
   parameter logic [7:0]  PRG_INDEX_B = 8'h41
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          dio_download,
   input  logic [7:0]    dio_index,
   input  logic          dio_wr,
   input  logic [AW-1:0] dio_addr,
   input  logic [7:0]    dio_data,
   output logic          wr,
   output logic [AW-1:0] addr,
   output logic [7:0]    data,
   output logic          downloading,
   output logic          rom_done,
   output logic          prg_done,
   output logic          err
);

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      PATCH,
      DONE
   } state_t;

   localparam int NB = NUM_PTRS * PTR_BYTES;

   state_t        state_q, state_d;
   logic [7:0]    idx_q, idx_d;
   logic [23:0]   cnt_q, cnt_d;
   logic [3:0]    pidx_q, pidx_d;
   logic [1:0]    bsel_q, bsel_d;
   logic          wr_q, wr_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [7:0]    data_q, data_d;
   logic          err_q, err_d;
   logic          rom_done_q, rom_done_d;
   logic          prg_done_q, prg_done_d;

   logic          is_rom;
   logic          is_prg;
   logic [23:0]   ptr_val;

   assign is_rom  = (idx_q == ROM_INDEX);
   assign is_prg  = (idx_q == PRG_INDEX_A) ||
                    (idx_q == PRG_INDEX_B);
   // pointer value: first address past the loaded program
   assign ptr_val = 24'(PRG_START) + cnt_q;

   function automatic logic [7:0] ptr_byte(
      input logic [1:0]  sel,
      input logic [23:0] v
   );
      logic [7:0] b;
      case (sel)
         2'd0:    b = v[7:0];
         2'd1:    b = v[15:8];
         default: b = v[23:16];
      endcase
      return b;
   endfunction

   // next-state and registered-output computation
   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      cnt_d      = cnt_q;
      pidx_d     = pidx_q;
      bsel_d     = bsel_q;
      wr_d       = 1'b0;
      addr_d     = addr_q;
      data_d     = data_q;
      err_d      = err_q;
      rom_done_d = rom_done_q;
      prg_done_d = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (dio_download) begin
               state_d = LOAD;
               idx_d   = dio_index;
               cnt_d   = '0;
               err_d   = 1'b0;
            end
         end
         LOAD: begin
            if (!is_rom && !is_prg) begin
               err_d = 1'b1;
            end
            if (!dio_download) begin
               if (is_prg) begin
                  state_d = PATCH;
                  pidx_d  = '0;
                  bsel_d  = '0;
                  wr_d    = 1'b1;
                  addr_d  = PTR_BASE;
                  data_d  = ptr_val[7:0];
               end else begin
                  state_d = DONE;
                  if (is_rom && !err_q) begin
                     rom_done_d = 1'b1;
                  end
               end
            end else if (dio_wr && (is_rom || is_prg)) begin
               if (is_rom && (dio_addr >= ROM_SIZE)) begin
                  err_d = 1'b1;
               end else begin
                  wr_d   = 1'b1;
                  addr_d = (is_rom ? ROM_START : PRG_START)
                           + dio_addr;
                  data_d = dio_data;
                  if (cnt_q != '1) begin
                     cnt_d = cnt_q + 24'd1;
                  end
               end
            end
         end
         PATCH: begin
            if (dio_download) begin
               // a new transfer preempts the patch
               state_d = LOAD;
               idx_d   = dio_index;
               cnt_d   = '0;
               err_d   = 1'b0;
            end else if (pidx_q == 4'(NB - 1)) begin
               state_d    = DONE;
               prg_done_d = 1'b1;
            end else begin
               pidx_d = pidx_q + 4'd1;
               bsel_d = (bsel_q == 2'(PTR_BYTES - 1)) ?
                        2'd0 : bsel_q + 2'd1;
               wr_d   = 1'b1;
               addr_d = PTR_BASE + AW'(pidx_d);
               data_d = ptr_byte(bsel_d, ptr_val);
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // state and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         idx_q      <= '0;
         cnt_q      <= '0;
         pidx_q     <= '0;
         bsel_q     <= '0;
         wr_q       <= 1'b0;
         addr_q     <= '0;
         data_q     <= '0;
         err_q      <= 1'b0;
         rom_done_q <= 1'b0;
         prg_done_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         cnt_q      <= cnt_d;
         pidx_q     <= pidx_d;
         bsel_q     <= bsel_d;
         wr_q       <= wr_d;
         addr_q     <= addr_d;
         data_q     <= data_d;
         err_q      <= err_d;
         rom_done_q <= rom_done_d;
         prg_done_q <= prg_done_d;
      end
   end

   assign wr          = wr_q;
   assign addr        = addr_q;
   assign data        = data_q;
   assign err         = err_q;
   assign rom_done    = rom_done_q;
   assign prg_done    = prg_done_q;
   assign downloading = (state_q == LOAD) ||
                        (state_q == PATCH);

endmodule

// File: tb/tb_multi_downloader.sv
// tb_multi_downloader: directed checks of ROM/PRG download,
// pointer patching, abort and reset behaviour.
module tb_multi_downloader;

   logic        clk = 1'b0;
   logic        reset;
   logic        dio_download;
   logic [7:0]  dio_index;
   logic        dio_wr;
   logic [24:0] dio_addr;
   logic [7:0]  dio_data;

   logic        wr, downloading, rom_done, prg_done, err;
   logic [24:0] addr;
   logic [7:0]  data;

   logic        wr3, downloading3, rom_done3, prg_done3, err3;
   logic [24:0] addr3;
   logic [7:0]  data3;

   int pass_cnt = 0;
   int total    = 0;

   logic [7:0] prg_bytes [3];

   always #5 clk = ~clk;

   multi_downloader dut (
      .clk          (clk),
      .reset        (reset),
      .dio_download (dio_download),
      .dio_index    (dio_index),
      .dio_wr       (dio_wr),
      .dio_addr     (dio_addr),
      .dio_data     (dio_data),
      .wr           (wr),
      .addr         (addr),
      .data         (data),
      .downloading  (downloading),
      .rom_done     (rom_done),
      .prg_done     (prg_done),
      .err          (err)
   );

   multi_downloader #(.NUM_PTRS(3), .PTR_BYTES(2)) dut3 (
      .clk          (clk),
      .reset        (reset),
      .dio_download (dio_download),
      .dio_index    (dio_index),
      .dio_wr       (dio_wr),
      .dio_addr     (dio_addr),
      .dio_data     (dio_data),
      .wr           (wr3),
      .addr         (addr3),
      .data         (data3),
      .downloading  (downloading3),
      .rom_done     (rom_done3),
      .prg_done     (prg_done3),
      .err          (err3)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic dl, input logic [7:0] idx,
                        input logic w, input logic [24:0] a,
                        input logic [7:0] d);
      dio_download = dl;
      dio_index    = idx;
      dio_wr       = w;
      dio_addr     = a;
      dio_data     = d;
   endtask

   task automatic idle(input int n);
      drive(1'b0, 8'h00, 1'b0, 25'h0, 8'h00);
      repeat (n) tick();
   endtask

   task automatic test_reset();
      reset = 1'b1;
      drive(1'b0, 8'h00, 1'b0, 25'h0, 8'h00);
      tick();
      tick();
      total++;
      if ({wr, downloading, rom_done, prg_done, err} !== 5'b0)
         $display("FAIL rst_flags got %b exp 00000",
                  {wr, downloading, rom_done, prg_done, err});
      else pass_cnt++;
      total++;
      if ({addr, data} !== 33'h0)
         $display("FAIL rst_bus got %h/%h exp 0/0", addr, data);
      else pass_cnt++;
      reset = 1'b0;
      tick();
   endtask

   task automatic test_prg();
      prg_bytes[0] = 8'hAA;
      prg_bytes[1] = 8'hBB;
      prg_bytes[2] = 8'hCC;
      drive(1'b1, 8'h01, 1'b0, 25'h0, 8'h00);
      tick();
      total++;
      if (downloading !== 1'b1)
         $display("FAIL prg_dl got %b exp 1", downloading);
      else pass_cnt++;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 8'h01, 1'b1, 25'(i), prg_bytes[i]);
         tick();
         total++;
         if ({wr, addr, data} !==
             {1'b1, 25'h8241 + 25'(i), prg_bytes[i]})
            $display("FAIL prg_wr%0d got %b %h %h exp 1 %h %h",
                     i, wr, addr, data,
                     25'h8241 + 25'(i), prg_bytes[i]);
         else pass_cnt++;
      end
      drive(1'b1, 8'h01, 1'b0, 25'h0, 8'h00);
      tick();
      drive(1'b0, 8'h00, 1'b0, 25'h0, 8'h00);
      tick();
      total++;
      if ({wr, addr, data, downloading} !==
          {1'b1, 25'h81BB, 8'h44, 1'b1})
         $display("FAIL prg_p0 got %b %h %h %b exp 1 81bb 44 1",
                  wr, addr, data, downloading);
      else pass_cnt++;
      tick();
      total++;
      if ({wr, addr, data, downloading} !==
          {1'b1, 25'h81BC, 8'h82, 1'b1})
         $display("FAIL prg_p1 got %b %h %h %b exp 1 81bc 82 1",
                  wr, addr, data, downloading);
      else pass_cnt++;
      tick();
      total++;
      if ({wr, downloading, prg_done} !== 3'b001)
         $display("FAIL prg_done got %b exp 001",
                  {wr, downloading, prg_done});
      else pass_cnt++;
      tick();
      total++;
      if (prg_done !== 1'b0)
         $display("FAIL prg_pulse got %b exp 0", prg_done);
      else pass_cnt++;
      idle(10);
   endtask

   task automatic test_rom_bound();
      drive(1'b1, 8'h00, 1'b0, 25'h0, 8'h00);
      tick();
      drive(1'b1, 8'h00, 1'b1, 25'h3FFF, 8'h5A);
      tick();
      total++;
      if ({wr, addr, data} !== {1'b1, 25'h3FFF, 8'h5A})
         $display("FAIL bnd_last got %b %h %h exp 1 3fff 5a",
                  wr, addr, data);
      else pass_cnt++;
      drive(1'b1, 8'h00, 1'b1, 25'h4000, 8'hA5);
      tick();
      total++;
      if ({wr, err} !== 2'b01)
         $display("FAIL bnd_drop got wr=%b err=%b exp 0 1", wr, err);
      else pass_cnt++;
      drive(1'b1, 8'h00, 1'b0, 25'h0, 8'h00);
      tick();
      drive(1'b0, 8'h00, 1'b0, 25'h0, 8'h00);
      tick();
      total++;
      if ({rom_done, err, downloading} !== 3'b010)
         $display("FAIL bnd_done got %b exp 010",
                  {rom_done, err, downloading});
      else pass_cnt++;
      idle(4);
   endtask

   task automatic test_rom();
      drive(1'b1, 8'h00, 1'b0, 25'h0, 8'h00);
      tick();
      total++;
      if ({downloading, err} !== 2'b10)
         $display("FAIL rom_start got %b exp 10", {downloading, err});
      else pass_cnt++;
      for (int i = 0; i < 16; i++) begin
         drive(1'b1, 8'h00, 1'b1, 25'(i), 8'h10 + 8'(i));
         tick();
         total++;
         if ({wr, addr, data} !== {1'b1, 25'(i), 8'h10 + 8'(i)})
            $display("FAIL rom_wr%0d got %b %h %h exp 1 %h %h",
                     i, wr, addr, data, 25'(i), 8'h10 + 8'(i));
         else pass_cnt++;
      end
      drive(1'b1, 8'h00, 1'b0, 25'h0, 8'h00);
      tick();
      total++;
      if (wr !== 1'b0)
         $display("FAIL rom_gap got %b exp 0", wr);
      else pass_cnt++;
      drive(1'b0, 8'h00, 1'b0, 25'h0, 8'h00);
      tick();
      total++;
      if ({wr, downloading, rom_done, err} !== 4'b0010)
         $display("FAIL rom_done got %b exp 0010",
                  {wr, downloading, rom_done, err});
      else pass_cnt++;
      tick();
      total++;
      if ({wr, downloading, addr, data} !==
          {1'b0, 1'b0, 25'h000F, 8'h1F})
         $display("FAIL rom_hold got %b %b %h %h exp 0 0 f 1f",
                  wr, downloading, addr, data);
      else pass_cnt++;
      idle(2);
   endtask

   task automatic test_multi();
      drive(1'b1, 8'h41, 1'b0, 25'h0, 8'h00);
      tick();
      for (int i = 0; i < 256; i++) begin
         drive(1'b1, 8'h41, 1'b1, 25'(i), 8'(i));
         tick();
         total++;
         if ({wr3, addr3, data3} !==
             {1'b1, 25'h8241 + 25'(i), 8'(i)})
            $display("FAIL mp_wr%0d got %b %h %h exp 1 %h %h",
                     i, wr3, addr3, data3,
                     25'h8241 + 25'(i), 8'(i));
         else pass_cnt++;
      end
      drive(1'b1, 8'h41, 1'b0, 25'h0, 8'h00);
      tick();
      drive(1'b0, 8'h00, 1'b0, 25'h0, 8'h00);
      tick();
      for (int j = 0; j < 6; j++) begin
         total++;
         if ({wr3, addr3, data3} !==
             {1'b1, 25'h81BB + 25'(j), (j % 2) ? 8'h83 : 8'h41})
            $display("FAIL mp_p%0d got %b %h %h exp 1 %h %h",
                     j, wr3, addr3, data3, 25'h81BB + 25'(j),
                     (j % 2) ? 8'h83 : 8'h41);
         else pass_cnt++;
         if (j < 2) begin
            total++;
            if ({wr, addr, data} !==
                {1'b1, 25'h81BB + 25'(j), (j % 2) ? 8'h83 : 8'h41})
               $display("FAIL sp_p%0d got %b %h %h", j, wr, addr, data);
            else pass_cnt++;
         end
         if (j == 2) begin
            total++;
            if ({wr, prg_done} !== 2'b01)
               $display("FAIL sp_done got %b exp 01", {wr, prg_done});
            else pass_cnt++;
         end
         tick();
      end
      total++;
      if ({wr3, downloading3, prg_done3} !== 3'b001)
         $display("FAIL mp_done got %b exp 001",
                  {wr3, downloading3, prg_done3});
      else pass_cnt++;
      total++;
      if ({rom_done, rom_done3} !== 2'b11)
         $display("FAIL rom_sticky got %b exp 11",
                  {rom_done, rom_done3});
      else pass_cnt++;
      idle(4);
   endtask

   task automatic test_abort();
      drive(1'b1, 8'h01, 1'b0, 25'h0, 8'h00);
      tick();
      drive(1'b1, 8'h01, 1'b1, 25'h0, 8'h11);
      tick();
      drive(1'b1, 8'h01, 1'b0, 25'h0, 8'h00);
      tick();
      drive(1'b0, 8'h00, 1'b0, 25'h0, 8'h00);
      tick();
      total++;
      if ({wr, addr, data} !== {1'b1, 25'h81BB, 8'h42})
         $display("FAIL ab_p0 got %b %h %h exp 1 81bb 42",
                  wr, addr, data);
      else pass_cnt++;
      drive(1'b1, 8'h01, 1'b0, 25'h0, 8'h00);
      tick();
      total++;
      if ({wr, downloading, prg_done} !== 3'b010)
         $display("FAIL ab_load got %b exp 010",
                  {wr, downloading, prg_done});
      else pass_cnt++;
      drive(1'b0, 8'h00, 1'b0, 25'h0, 8'h00);
      tick();
      total++;
      if ({wr, addr, data} !== {1'b1, 25'h81BB, 8'h41})
         $display("FAIL zero_p0 got %b %h %h exp 1 81bb 41",
                  wr, addr, data);
      else pass_cnt++;
      tick();
      total++;
      if ({wr, addr, data} !== {1'b1, 25'h81BC, 8'h82})
         $display("FAIL zero_p1 got %b %h %h exp 1 81bc 82",
                  wr, addr, data);
      else pass_cnt++;
      tick();
      total++;
      if (prg_done !== 1'b1)
         $display("FAIL zero_done got %b exp 1", prg_done);
      else pass_cnt++;
      idle(10);
   endtask

   task automatic test_reset_patch();
      drive(1'b1, 8'h01, 1'b0, 25'h0, 8'h00);
      tick();
      drive(1'b1, 8'h01, 1'b1, 25'h0, 8'h77);
      tick();
      drive(1'b1, 8'h01, 1'b0, 25'h0, 8'h00);
      tick();
      drive(1'b0, 8'h00, 1'b0, 25'h0, 8'h00);
      tick();
      tick();
      total++;
      if ({wr, addr, data} !== {1'b1, 25'h81BC, 8'h82})
         $display("FAIL rp_p1 got %b %h %h exp 1 81bc 82",
                  wr, addr, data);
      else pass_cnt++;
      reset = 1'b1;
      tick();
      total++;
      if ({wr, downloading, prg_done, rom_done, err, addr, data}
          !== 38'h0)
         $display("FAIL rp_reset got %b%b%b%b%b %h %h exp all 0",
                  wr, downloading, prg_done, rom_done, err,
                  addr, data);
      else pass_cnt++;
      total++;
      if ({wr3, downloading3, rom_done3} !== 3'b000)
         $display("FAIL rp_reset3 got %b exp 000",
                  {wr3, downloading3, rom_done3});
      else pass_cnt++;
      reset = 1'b0;
      drive(1'b1, 8'h07, 1'b0, 25'h0, 8'h00);
      tick();
      total++;
      if (downloading !== 1'b1)
         $display("FAIL unk_dl got %b exp 1", downloading);
      else pass_cnt++;
      drive(1'b1, 8'h07, 1'b1, 25'h0, 8'h99);
      tick();
      total++;
      if ({wr, err} !== 2'b01)
         $display("FAIL unk_wr got wr=%b err=%b exp 0 1", wr, err);
      else pass_cnt++;
      drive(1'b0, 8'h00, 1'b0, 25'h0, 8'h00);
      tick();
      total++;
      if ({wr, downloading, rom_done, prg_done, err} !== 5'b00001)
         $display("FAIL unk_done got %b exp 00001",
                  {wr, downloading, rom_done, prg_done, err});
      else pass_cnt++;
      idle(2);
   endtask

   initial begin
      test_reset();
      test_prg();
      test_rom_bound();
      test_rom();
      test_multi();
      test_abort();
      test_reset_patch();
      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end

endmodule

// File: doc/multi_downloader.md
MULTI_DOWNLOADER -- requirements
Module: multi_downloader

Interface
REQ-001 The block SHALL expose these parameters (name, default, meaning), one per line:
- AW, 25, address width of addr and dio_addr.
- ROM_START, 25'h0, base address for ROM images.
- ROM_SIZE, 25'h4000, ROM window length in bytes.
- PRG_START, 25'h8241, base address for BASIC program images.
- PTR_BASE, 25'h81BB, address of the first patched pointer.
- NUM_PTRS, 1, number of pointers patched after a PRG load (1..4).
- PTR_BYTES, 2, bytes per pointer (1..3), little-endian.
- ROM_INDEX, 8'h00, dio_index value selecting ROM.
- PRG_INDEX_A, 8'h01, first dio_index value selecting PRG.
- PRG_INDEX_B, 8'h41, second dio_index value selecting PRG.
REQ-002 The block SHALL have one clock and a synchronous, active-high reset.
REQ-003 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, system clock.
- reset, in, 1, synchronous active-high reset.
- dio_download, in, 1, transfer-active flag from data_io.
- dio_index, in, 8, file type from data_io.
- dio_wr, in, 1, byte strobe from data_io.
- dio_addr, in, AW, byte offset from data_io.
- dio_data, in, 8, byte value from data_io.
- wr, out, 1, memory write strobe.
- addr, out, AW, memory address.
- data, out, 8, memory data.
- downloading, out, 1, the block owns the memory bus.
- rom_done, out, 1, sticky: a ROM image has completed since reset.
- prg_done, out, 1, one-cycle pulse when a PRG load and its patch complete.
- err, out, 1, sticky error flag for the last transfer.

Function
REQ-004 The block SHALL use four states: IDLE, LOAD, PATCH, DONE.
REQ-005 In IDLE, dio_download=1 SHALL enter LOAD, latch dio_index, clear the byte counter and clear err.
REQ-006 Type selection:
- ROM when the latched index equals ROM_INDEX.
- PRG when it equals PRG_INDEX_A or PRG_INDEX_B.
- Any other value is UNKNOWN.
REQ-007 In LOAD, downloading SHALL be 1, and wr, addr and data SHALL be registered from dio_* with exactly one clk of latency.
REQ-008 LOAD address mapping:
- ROM: addr = ROM_START + dio_addr.
- PRG: addr = PRG_START + dio_addr.
- Sums truncate to AW bits.
REQ-009 Every dio_wr=1 cycle forwarded in LOAD SHALL increment a 24-bit byte counter, saturating at all-ones.
REQ-010 A ROM write with dio_addr >= ROM_SIZE SHALL be dropped (wr=0) and SHALL set err; the counter is not incremented.
REQ-011 An UNKNOWN transfer SHALL keep downloading=1, SHALL force wr=0 throughout and SHALL set err.
REQ-012 In LOAD, the first cycle with dio_download=0 SHALL go to PATCH for PRG and to DONE for ROM and UNKNOWN; wr SHALL be 0 in that cycle.
REQ-013 In PATCH, the block SHALL write NUM_PTRS*PTR_BYTES bytes on consecutive cycles with wr=1 and downloading=1.
REQ-014 Pointer i (0-based) SHALL be written at PTR_BASE + i*PTR_BYTES, low byte first.
REQ-015 The value of every pointer SHALL be V = PRG_START + counter, truncated to 8*PTR_BYTES bits (the address of the byte after the program).
REQ-016 After the last patch byte, PATCH SHALL go to DONE.
REQ-017 DONE SHALL last one cycle with wr=0 and downloading=0, then go to IDLE, with these effects:
- ROM without err sets rom_done.
- PRG pulses prg_done.
- UNKNOWN or erroneous ROM sets neither.
REQ-018 dio_download=1 in PATCH SHALL abort the patch and enter LOAD as in REQ-005; prg_done SHALL NOT pulse.
REQ-019 A PRG load of zero bytes SHALL still patch, with V = PRG_START.
REQ-020 In IDLE, wr and downloading SHALL be 0; addr and data SHALL hold their last values.
REQ-021 rom_done SHALL stay set across later PRG or UNKNOWN transfers and SHALL clear only on reset.

Reset
REQ-022 reset=1 SHALL, on the next clk edge and from any state including mid-LOAD or mid-PATCH:
- force IDLE;
- set wr, downloading, prg_done, rom_done and err to 0;
- set addr and data to 0;
- clear the counter and the latched index.
REQ-023 After reset, an in-progress transfer (dio_download still 1) SHALL be treated as a new transfer starting at the next cycle.

Verification
REQ-024 PRG test, defaults, index 8'h01, 3 bytes AA,BB,CC at offsets 0..2:
- writes 8241=AA, 8242=BB, 8243=CC;
- then 81BB=44, 81BC=82;
- then a one-cycle prg_done.
REQ-025 ROM test, index 0, 16 bytes:
- writes to 0000..000F, each one clk after its dio_wr;
- no patch writes;
- rom_done=1 after DONE; err=0.
REQ-026 ROM test with dio_addr 3FFF then 4000:
- 3FFF is written;
- 4000 is dropped and err=1;
- rom_done stays 0.
REQ-027 Multi-pointer PRG test, NUM_PTRS=3, PTR_BYTES=2, 256 bytes:
- six patch writes, to 81BB..81C0;
- each pointer equals 0x8341, written 41,83.
REQ-028 Reset test: reset asserted during the 2nd patch byte:
- the next cycle shows wr=0, downloading=0, state IDLE;
- a following index 8'h07 transfer gives no writes and err=1.
